// File: rtl/uart_cmd_dispatcher_if.sv
// Configuration write channel from the command dispatcher to the PWM/DDS register banks.
interface uart_cmd_dispatcher_if;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  cfg_func;
  logic [7:0]  cfg_ch;
  logic        cfg_en;
  logic [7:0]  cfg_duty;
  logic [15:0] cfg_dessert;
  logic [7:0]  cfg_pulse_num;
  logic [31:0] cfg_pattern;

  modport master (
    output cfg_valid, cfg_func, cfg_ch, cfg_en, cfg_duty, cfg_dessert, cfg_pulse_num, cfg_pattern,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_func, cfg_ch, cfg_en, cfg_duty, cfg_dessert, cfg_pulse_num, cfg_pattern,
    output cfg_ready
  );
endinterface

// File: rtl/uart_cmd_dispatcher.sv
// Parses 14-byte UART command frames and issues one configuration write per good frame.
// Optional CRC checking of the payload XOR is enabled by defining CMD_CRC_CHECK_EN.
module uart_cmd_dispatcher #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter logic [7:0]  HDR_BYTE    = 8'h55,
  parameter logic [7:0]  TAIL_BYTE   = 8'hAA
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_done,
  uart_cmd_dispatcher_if.master        cfg,
  output logic                         frame_ok,
  output logic                         frame_err,
  output logic [2:0]                   err_code,
  output logic                         busy
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] TMO_MAX = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_PAYLOAD, S_CRC, S_TAIL, S_DISPATCH} state_e;
  typedef enum logic [2:0] {
    E_NONE = 3'd0, E_TAIL = 3'd1, E_FUNC_CH = 3'd2, E_TIMEOUT = 3'd3, E_CRC = 3'd4, E_OVERRUN = 3'd5
  } err_e;

  state_e            state_q, state_d;
  err_e              err_q, err_d;
  logic [3:0]        idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovr_q, ovr_d;
  logic [7:0]        func_q, func_d, ch_q, ch_d, duty_q, duty_d, pulse_q, pulse_d;
  logic              en_q, en_d;
  logic [15:0]       dessert_q, dessert_d;
  logic [31:0]       pattern_q, pattern_d;
  logic              counting, timeout, ovr_now, func_ok, ch_ok;
`ifdef CMD_CRC_CHECK_EN
  logic [7:0]        crc_rx_q, crc_rx_d, crc_acc_q, crc_acc_d;
`endif

  assign func_ok = (func_q == 8'h01) || (func_q == 8'h02);
  assign ch_ok   = 32'(ch_q) < NUM_CH;

  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    idx_d     = idx_q;
    ovr_d     = ovr_q;
    func_d    = func_q;
    ch_d      = ch_q;
    en_d      = en_q;
    duty_d    = duty_q;
    dessert_d = dessert_q;
    pulse_d   = pulse_q;
    pattern_d = pattern_q;
    frame_ok  = 1'b0;
    frame_err = 1'b0;
    ovr_now   = 1'b0;
`ifdef CMD_CRC_CHECK_EN
    crc_rx_d  = crc_rx_q;
    crc_acc_d = crc_acc_q;
`endif
    counting = (state_q == S_PAYLOAD) || (state_q == S_CRC) || (state_q == S_TAIL);
    timeout  = counting && (cnt_q == TMO_MAX);
    cnt_d    = '0;
    if (counting && !timeout && !rx_done) cnt_d = cnt_q + CNT_W'(1);

    // Expiry takes precedence over a byte arriving in the same cycle.
    if (timeout) begin
      frame_err = 1'b1;
      err_d     = E_TIMEOUT;
      state_d   = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rx_done && rx_data == HDR_BYTE) begin
            state_d = S_PAYLOAD;
            idx_d   = '0;
`ifdef CMD_CRC_CHECK_EN
            crc_acc_d = '0;
`endif
          end
        end
        S_PAYLOAD: begin
          if (rx_done) begin
            case (idx_q)
              4'd0:    func_d            = rx_data;
              4'd1:    ch_d              = rx_data;
              4'd2:    en_d              = rx_data[0];
              4'd3:    duty_d            = rx_data;
              4'd4:    dessert_d[15:8]   = rx_data;
              4'd5:    dessert_d[7:0]    = rx_data;
              4'd6:    pulse_d           = rx_data;
              4'd7:    pattern_d[31:24]  = rx_data;
              4'd8:    pattern_d[23:16]  = rx_data;
              4'd9:    pattern_d[15:8]   = rx_data;
              default: pattern_d[7:0]    = rx_data;
            endcase
`ifdef CMD_CRC_CHECK_EN
            crc_acc_d = crc_acc_q ^ rx_data;
`endif
            if (idx_q == 4'd10) state_d = S_CRC;
            else                idx_d   = idx_q + 4'd1;
          end
        end
        S_CRC: begin
          if (rx_done) begin
`ifdef CMD_CRC_CHECK_EN
            crc_rx_d = rx_data;
`endif
            state_d = S_TAIL;
          end
        end
        S_TAIL: begin
          if (rx_done) begin
            state_d = S_IDLE;
            if (rx_data != TAIL_BYTE) begin
              frame_err = 1'b1;
              err_d     = E_TAIL;
            end else if (!func_ok || !ch_ok) begin
              frame_err = 1'b1;
              err_d     = E_FUNC_CH;
            end
`ifdef CMD_CRC_CHECK_EN
            else if (crc_rx_q != crc_acc_q) begin
              frame_err = 1'b1;
              err_d     = E_CRC;
            end
`endif
            else begin
              state_d = S_DISPATCH;
              ovr_d   = 1'b0;
            end
          end
        end
        S_DISPATCH: begin
          ovr_now = ovr_q || rx_done;
          ovr_d   = ovr_now;
          if (cfg.cfg_ready) begin
            frame_ok  = 1'b1;
            frame_err = ovr_now;
            err_d     = ovr_now ? E_OVERRUN : E_NONE;
            state_d   = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (sys_rst) begin
      frame_ok  = 1'b0;
      frame_err = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= S_IDLE;
      err_q     <= E_NONE;
      idx_q     <= '0;
      cnt_q     <= '0;
      ovr_q     <= 1'b0;
      func_q    <= '0;
      ch_q      <= '0;
      en_q      <= 1'b0;
      duty_q    <= '0;
      dessert_q <= '0;
      pulse_q   <= '0;
      pattern_q <= '0;
`ifdef CMD_CRC_CHECK_EN
      crc_rx_q  <= '0;
      crc_acc_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      ovr_q     <= ovr_d;
      func_q    <= func_d;
      ch_q      <= ch_d;
      en_q      <= en_d;
      duty_q    <= duty_d;
      dessert_q <= dessert_d;
      pulse_q   <= pulse_d;
      pattern_q <= pattern_d;
`ifdef CMD_CRC_CHECK_EN
      crc_rx_q  <= crc_rx_d;
      crc_acc_q <= crc_acc_d;
`endif
    end
  end

  assign cfg.cfg_valid     = (state_q == S_DISPATCH);
  assign cfg.cfg_func      = func_q;
  assign cfg.cfg_ch        = ch_q;
  assign cfg.cfg_en        = en_q;
  assign cfg.cfg_duty      = duty_q;
  assign cfg.cfg_dessert   = dessert_q;
  assign cfg.cfg_pulse_num = pulse_q;
  assign cfg.cfg_pattern   = pattern_q;
  assign err_code          = err_q;
  assign busy              = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_dispatcher.sv
// Randomised frame-level bench for uart_cmd_dispatcher with a frame-outcome reference model.
module tb_uart_cmd_dispatcher;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned T      = 200;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = '0;
  logic       frame_ok, frame_err, busy;
  logic [2:0] err_code;

  uart_cmd_dispatcher_if cfg_if ();

  uart_cmd_dispatcher #(
    .NUM_CH     (NUM_CH),
    .TIMEOUT_CYC(T),
    .HDR_BYTE   (8'h55),
    .TAIL_BYTE  (8'hAA)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .cfg      (cfg_if),
    .frame_ok (frame_ok),
    .frame_err(frame_err),
    .err_code (err_code),
    .busy     (busy)
  );

  always #10 sys_clk = ~sys_clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [80:0] got, input logic [80:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic [80:0] fields;
  assign fields = {cfg_if.cfg_func, cfg_if.cfg_ch, cfg_if.cfg_en, cfg_if.cfg_duty,
                   cfg_if.cfg_dessert, cfg_if.cfg_pulse_num, cfg_if.cfg_pattern};

  int          ok_n = 0, err_n = 0, both_n = 0, vcyc_n = 0, stab_n = 0;
  logic [80:0] cap = '0, held = '0;
  bit          prev_v = 1'b0;

  always @(negedge sys_clk) begin
    if (cfg_if.cfg_valid) begin
      vcyc_n++;
      if (prev_v && fields !== held) stab_n++;
      held = fields;
    end
    prev_v = cfg_if.cfg_valid;
    if (frame_ok) begin
      ok_n++;
      cap = fields;
    end
    if (frame_err) err_n++;
    if (frame_ok && frame_err) both_n++;
  end

  logic [7:0] fr [14];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick(1);
    rx_done = 1'b0;
  endtask

  task automatic load(input logic [111:0] v);
    for (int i = 0; i < 14; i++) fr[i] = v[111-8*i -: 8];
  endtask

  function automatic logic [7:0] junk_byte();
    logic [7:0] b;
    b = 8'($urandom);
    if (b == 8'h55) b = 8'h56;
    return b;
  endfunction

  // Frame outcome from the frame rules alone: what was sent, how late the tail was, and any overrun.
  task automatic model(input int nsend, input int last_gap, input int injected,
                       output bit eok, output bit eerr, output logic [2:0] ecode);
    logic [7:0] x;
    x = '0;
    for (int i = 1; i <= 11; i++) x ^= fr[i];
    eok = 1'b0;
    eerr = 1'b1;
    if (nsend < 14 || last_gap >= int'(T) - 1) ecode = 3'd3;
    else if (fr[13] != 8'hAA) ecode = 3'd1;
    else if (!(fr[1] == 8'h01 || fr[1] == 8'h02) || 32'(fr[2]) >= NUM_CH) ecode = 3'd2;
`ifdef CMD_CRC_CHECK_EN
    else if (fr[12] != x) ecode = 3'd4;
`endif
    else begin
      eok   = 1'b1;
      eerr  = (injected > 0);
      ecode = (injected > 0) ? 3'd5 : 3'd0;
    end
  endtask

  task automatic run_frame(input int nsend, input int last_gap, input int hold, input int inj);
    int b_ok, b_err, b_both, b_v, b_stab, injected, step;
    bit eok, eerr;
    logic [2:0] ecode;
    logic [80:0] efields;
    b_ok = ok_n; b_err = err_n; b_both = both_n; b_v = vcyc_n; b_stab = stab_n;
    injected = 0;
    cfg_if.cfg_ready = (hold == 0);
    for (int i = 0; i < nsend; i++) begin
      if (i > 0) tick((i == 13) ? last_gap : int'($urandom_range(0, 3)));
      send_byte(fr[i]);
    end
    if (nsend < 14) tick(int'(T) + 3);
    if (hold > 0) begin
      step = hold / (inj + 1);
      for (int c = 0; c < hold; c++) begin
        if (injected < inj && c > 0 && (c % step) == 0) begin
          send_byte(junk_byte());
          injected++;
        end else tick(1);
      end
    end
    cfg_if.cfg_ready = 1'b1;
    for (int k = 0; k < 40 && (busy || cfg_if.cfg_valid); k++) tick(1);
    tick(2);

    model(nsend, last_gap, injected, eok, eerr, ecode);
    efields = {fr[1], fr[2], fr[3][0], fr[4], fr[5], fr[6], fr[7], fr[8], fr[9], fr[10], fr[11]};
    check("ok_count", 81'(ok_n - b_ok), 81'(eok));
    check("err_count", 81'(err_n - b_err), 81'(eerr));
    check("err_code", 81'(err_code), 81'(ecode));
    check("busy_after", 81'(busy), 81'(0));
    check("valid_stable", 81'(stab_n - b_stab), 81'(0));
    if (eok) begin
      check("fields", cap, efields);
      check("valid_cycles", 81'(vcyc_n - b_v), 81'(hold + 1));
      check("ok_err_same_cycle", 81'(both_n - b_both), 81'(eerr));
    end else begin
      check("no_valid", 81'(vcyc_n - b_v), 81'(0));
    end
  endtask

  task automatic gen_frame();
    logic [7:0] x;
    fr[0] = 8'h55;
    fr[1] = ($urandom_range(0, 9) < 7) ? 8'($urandom_range(1, 2)) : 8'($urandom);
    fr[2] = ($urandom_range(0, 9) < 8) ? 8'($urandom_range(0, NUM_CH - 1)) : 8'($urandom);
    x = fr[1] ^ fr[2];
    for (int i = 3; i <= 11; i++) begin
      fr[i] = 8'($urandom);
      x ^= fr[i];
    end
    fr[12] = ($urandom_range(0, 9) < 7) ? x : 8'($urandom);
    fr[13] = ($urandom_range(0, 9) < 8) ? 8'hAA : 8'($urandom);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    cfg_if.cfg_ready = 1'b0;
    tick(3);
    sys_rst = 1'b0;
    check("rst_valid", 81'(cfg_if.cfg_valid), 81'(0));
    check("rst_busy", 81'(busy), 81'(0));
    check("rst_err_code", 81'(err_code), 81'(0));
    check("rst_pulses", 81'({frame_ok, frame_err}), 81'(0));
    check("rst_fields", fields, 81'(0));

    load(112'h55_01_01_01_03_00_44_00_00_00_00_FF_0C_AA);
    run_frame(14, 1, 0, 0);
    load(112'h55_01_01_01_FF_07_30_00_FF_FF_FF_FF_0C_AB);
    run_frame(14, 1, 0, 0);
    load(112'h55_02_12_13_14_15_16_17_18_19_1A_1B_1C_AA);
    run_frame(14, 1, 0, 0);
    load(112'h55_01_01_01_03_00_44_00_00_00_00_FF_0C_AA);
    run_frame(3, 1, 0, 0);
    run_frame(14, 1, 0, 0);
    run_frame(14, 1, 200, 3);
    run_frame(14, int'(T) - 2, 0, 0);
    run_frame(14, int'(T) - 1, 0, 0);
    load(112'h55_01_01_01_03_00_44_00_00_00_00_FF_B9_AA);
    run_frame(14, 1, 0, 0);
    load(112'h55_01_00_55_55_55_55_55_55_55_55_55_54_AA);
    run_frame(14, 0, 0, 0);

    // Reset while a write is pending, then reset mid-frame followed by a clean frame.
    load(112'h55_01_01_01_03_00_44_00_00_00_00_FF_B9_AA);
    cfg_if.cfg_ready = 1'b0;
    k = ok_n;
    for (int i = 0; i < 14; i++) send_byte(fr[i]);
    tick(5);
    check("pre_rst_valid", 81'(cfg_if.cfg_valid), 81'(1));
    sys_rst = 1'b1;
    tick(1);
    check("rst_dispatch_valid", 81'(cfg_if.cfg_valid), 81'(0));
    check("rst_dispatch_busy", 81'(busy), 81'(0));
    check("rst_dispatch_err", 81'(err_code), 81'(0));
    sys_rst = 1'b0;
    cfg_if.cfg_ready = 1'b1;
    tick(3);
    check("rst_no_ok", 81'(ok_n - k), 81'(0));
    send_byte(8'h55);
    send_byte(8'h01);
    send_byte(8'h02);
    sys_rst = 1'b1;
    tick(1);
    sys_rst = 1'b0;
    run_frame(14, 1, 0, 0);

    for (int n = 0; n < 60; n++) begin
      gen_frame();
      repeat ($urandom_range(0, 2)) begin
        tick(int'($urandom_range(0, 2)));
        send_byte(junk_byte());
      end
      k = int'($urandom_range(0, 9));
      if (k <= 5)      run_frame(14, int'($urandom_range(0, 3)), 0, 0);
      else if (k == 6) run_frame(int'($urandom_range(1, 13)), 0, 0, 0);
      else if (k == 7) run_frame(14, int'(T) - 2 + int'($urandom_range(0, 1)), 0, 0);
      else             run_frame(14, 1, int'($urandom_range(5, 40)), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/uart_cmd_dispatcher.md
Name: uart_cmd_dispatcher

Overview:
Frame parser and configuration sequencer between the UART receiver and the PWM/DDS channel register banks in dds_sample_top. It consumes received bytes and validates the fixed 14-byte command frame. It then issues one valid/ready configuration write per good frame to the addressed channel, and reports frame status to the LED/debug logic.

Parameters:
NUM_CH, 4, number of addressable channels; hs_pwm_ch values >= NUM_CH are rejected
TIMEOUT_CYC, 50000, maximum sys_clk cycles allowed between bytes inside a frame (1 ms at 50 MHz)
HDR_BYTE, 8'h55, frame header
TAIL_BYTE, 8'hAA, frame tail

Ports:
sys_clk  in  1  system clock, 50 MHz
sys_rst  in  1  synchronous, active-high reset
rx_data  in  8  byte from the UART receiver
rx_done  in  1  one-cycle strobe; rx_data is valid in that cycle
cfg_valid  out  1  configuration write request
cfg_ready  in  1  channel bank accepts the request
cfg_func  out  8  reg_func byte (0x01 = PWM config, 0x02 = DDS config)
cfg_ch  out  8  target channel
cfg_en  out  1  hs_ctrl_sta bit 0
cfg_duty  out  8  duty_num
cfg_dessert  out  16  pulse_dessert, high byte first on the wire
cfg_pulse_num  out  8  pulse_num
cfg_pattern  out  32  PAT bytes, first byte received = bits [31:24]
frame_ok  out  1  one-cycle pulse when cfg_valid&&cfg_ready
frame_err  out  1  one-cycle pulse on any rejected frame
err_code  out  3  last error, held until the next frame_ok/frame_err: 0 none, 1 bad tail, 2 bad func/ch, 3 timeout, 4 CRC, 5 overrun
busy  out  1  high in every state other than IDLE

Behaviour:
- Reset: state IDLE; every output 0; byte index 0; timeout counter 0.
- Frame layout: HDR, func, ch, sta, duty, dessert_h, dessert_l, pulse_num, pat0..pat3, crc, TAIL. The 11 bytes from func to pat3 are the payload.
- States: IDLE -> PAYLOAD -> CRC -> TAIL -> DISPATCH -> IDLE.
- IDLE: a byte equal to HDR_BYTE on rx_done -> PAYLOAD with index 0. Any other byte is discarded silently, with no error.
- PAYLOAD: each rx_done stores the byte into its shadow register and increments the index. After index 10 -> CRC.
- CRC: the next byte is latched as crc_rx -> TAIL.
- TAIL:
  - byte != TAIL_BYTE -> frame_err, err_code=1, go to IDLE.
  - byte == TAIL_BYTE -> check func (must be 0x01 or 0x02) and ch (must be < NUM_CH); on failure -> err_code=2, go to IDLE.
  - Otherwise -> DISPATCH.
- Error priority: tail > func/ch > CRC.
- DISPATCH: cfg_valid rises in the cycle after the tail's rx_done. All cfg_* outputs are driven from the shadow registers and held stable while cfg_valid=1. On cfg_valid&&cfg_ready: frame_ok pulses the same cycle, cfg_valid drops next cycle, state -> IDLE.
- Overrun: any rx_done during DISPATCH is dropped and sets a sticky overrun flag. On handshake completion, err_code=5 and frame_err pulses in the same cycle as frame_ok. The configuration write is still delivered.
- Timeout: the counter clears on every rx_done and counts in PAYLOAD, CRC and TAIL. On reaching TIMEOUT_CYC-1 -> frame_err, err_code=3, go to IDLE. The counter does not run in IDLE or DISPATCH.
- An HDR_BYTE received mid-frame is treated as ordinary data; there is no resynchronisation.
- rx_done in the same cycle as a timeout expiry: the timeout wins and the byte is discarded.
- sys_rst mid-frame or mid-DISPATCH: immediate return to reset values. A pending cfg_valid is withdrawn without a handshake.
- Shadow registers are updated only in PAYLOAD, so cfg_* never change during DISPATCH.

Optional Feature:
CMD_CRC_CHECK_EN
- Defined: in TAIL, after the tail and func/ch checks pass, crc_rx must equal the XOR of the 11 payload bytes, accumulated on the fly. On mismatch -> frame_err, err_code=4, no cfg_valid.
- Undefined: the CRC byte is consumed and ignored, and no XOR accumulator is synthesised.

Test Plan:
- Macro off, NUM_CH=4. Send 55 01 01 01 03 00 44 00 00 00 00 FF 0C AA with cfg_ready=1 -> cfg_valid for 1 cycle with ch=1, en=1, duty=0x03, dessert=0x0044, pulse_num=0, pattern=0x000000FF; frame_ok pulse; err_code=0.
- Send 55 01 01 01 FF 07 30 00 FF FF FF FF 0C AB -> frame_err, err_code=1, no cfg_valid, busy=0 afterwards.
- Send 55 02 12 13 14 15 16 17 18 19 1A 1B 1C AA -> err_code=2 (ch=0x12); no cfg_valid.
- Send 55 01 01 then idle for TIMEOUT_CYC cycles -> frame_err, err_code=3. Then send the first frame -> frame_ok, showing recovery.
- Hold cfg_ready=0 for 200 cycles after a good frame and inject 3 bytes -> cfg_valid and fields stable throughout. On release: frame_ok and frame_err in the same cycle, err_code=5.
- Macro on: first frame with CRC 0xB9 -> frame_ok. Same frame with CRC 0x0C -> err_code=4, no cfg_valid.
